// File: rtl/parking_lot_ctrl_if.sv
// rtl/parking_lot_ctrl_if.sv - sensor and occupancy signal bundle for the parking lot controller
//
// Purpose : groups the per-gate beam sensors and the occupancy outputs of
//           parking_lot_ctrl so they travel as one port.
// Signals : outer/inner     per-gate beam sensors, 1 = blocked
//           enter/exit      per-gate one-cycle pulses, completed entry/exit
//           count           current occupancy (CW bits)
//           full/empty      occupancy decodes
//           denied          one-cycle pulse, entries lost to saturation
//           total_entries   counted entries since reset, wraps modulo 2^16
// Modports: master drives the sensors, slave is the controller.
interface parking_lot_ctrl_if #(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 16
);
    localparam int CW = $clog2(CAPACITY + 1);

    logic [NUM_GATES-1:0] outer;
    logic [NUM_GATES-1:0] inner;
    logic [NUM_GATES-1:0] enter;
    logic [NUM_GATES-1:0] exit;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 denied;
    logic [15:0]          total_entries;

    modport master (
        output outer, inner,
        input  enter, exit, count, full, empty, denied, total_entries
    );

    modport slave (
        input  outer, inner,
        output enter, exit, count, full, empty, denied, total_entries
    );
endinterface

// File: rtl/parking_lot_ctrl.sv
// rtl/parking_lot_ctrl.sv - multi-gate two-sensor parking lot occupancy controller
//
// Purpose : one direction-detecting FSM per gate turns the outer/inner beam
//           sequence into registered enter/exit pulses; the pulses are then
//           summed into a saturating occupancy count with an entry tally.
// Ports   : clk            system clock, rising edge
//           reset          synchronous, active-high
//           bus (slave)    outer/inner sensors in; enter, exit, count, full,
//                          empty, denied, total_entries out
// Latency : edge sampling the final 00 -> pulse; pulse -> count (2 clocks).
module parking_lot_ctrl #(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 16
) (
    input logic               clk,
    input logic               reset,
    parking_lot_ctrl_if.slave bus
);
    localparam int CW = $clog2(CAPACITY + 1);
    localparam int AW = CW + 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } gate_state_t;

    gate_state_t          state_q [NUM_GATES];
    gate_state_t          state_d [NUM_GATES];
    logic [NUM_GATES-1:0] enter_d, exit_d;
    logic [NUM_GATES-1:0] enter_q, exit_q;

    logic [CW-1:0]        count_q, count_d;
    logic                 denied_q, denied_d;
    logic [15:0]          total_q, total_d;

    // ---------------------------------------------------------------
    // Gate FSMs: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int g = 0; g < NUM_GATES; g++) begin
            if (reset) begin
                state_q[g] <= IDLE;
            end else begin
                state_q[g] <= state_d[g];
            end
        end
    end

    // ---------------------------------------------------------------
    // Gate FSMs: next state. Code is {outer, inner}; any code not
    // listed as a hold or an advance abandons the car back to IDLE.
    // ---------------------------------------------------------------
    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            logic [1:0] code;
            code       = {bus.outer[g], bus.inner[g]};
            state_d[g] = IDLE;
            case (state_q[g])
                IDLE: begin
                    if (code == 2'b10)      state_d[g] = EN1;
                    else if (code == 2'b01) state_d[g] = EX1;
                end
                EN1: begin
                    if (code == 2'b11)      state_d[g] = EN2;
                    else if (code == 2'b10) state_d[g] = EN1;
                end
                EN2: begin
                    if (code == 2'b01)      state_d[g] = EN3;
                    else if (code == 2'b10) state_d[g] = EN1;
                    else if (code == 2'b11) state_d[g] = EN2;
                end
                EN3: begin
                    if (code == 2'b11)      state_d[g] = EN2;
                    else if (code == 2'b01) state_d[g] = EN3;
                end
                EX1: begin
                    if (code == 2'b11)      state_d[g] = EX2;
                    else if (code == 2'b01) state_d[g] = EX1;
                end
                EX2: begin
                    if (code == 2'b10)      state_d[g] = EX3;
                    else if (code == 2'b01) state_d[g] = EX1;
                    else if (code == 2'b11) state_d[g] = EX2;
                end
                EX3: begin
                    if (code == 2'b11)      state_d[g] = EX2;
                    else if (code == 2'b10) state_d[g] = EX3;
                end
                default: state_d[g] = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Gate FSMs: outputs. A pulse is due when the last sensor clears
    // from the third step of a sequence.
    // ---------------------------------------------------------------
    always_comb begin
        enter_d = '0;
        exit_d  = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            if (!bus.outer[g] && !bus.inner[g]) begin
                enter_d[g] = (state_q[g] == EN3);
                exit_d[g]  = (state_q[g] == EX3);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enter_q <= '0;
            exit_q  <= '0;
        end else begin
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    // ---------------------------------------------------------------
    // Occupancy. Signed arithmetic four bits wider than the count so the
    // sum can neither wrap above CAPACITY nor below zero before clamping.
    // ---------------------------------------------------------------
    logic signed [AW-1:0] cur_s, e_s, x_s, sum_s, cap_s, added_s;

    always_comb begin
        cur_s = $signed({4'b0000, count_q});
        cap_s = AW'(CAPACITY);
        e_s   = '0;
        x_s   = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            e_s = e_s + $signed({{(AW-1){1'b0}}, enter_q[g]});
            x_s = x_s + $signed({{(AW-1){1'b0}}, exit_q[g]});
        end
        sum_s    = cur_s + e_s - x_s;
        count_d  = sum_s[CW-1:0];
        denied_d = 1'b0;
        added_s  = e_s;
        if (sum_s > cap_s) begin
            // Only the entries that fit are counted; exits in the same
            // cycle make room for that many extra entries.
            count_d  = cap_s[CW-1:0];
            denied_d = 1'b1;
            added_s  = cap_s - cur_s + x_s;
        end else if (sum_s < 0) begin
            count_d = '0;
        end
        total_d = total_q + 16'($unsigned(added_s));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            denied_q <= 1'b0;
            total_q  <= '0;
        end else begin
            count_q  <= count_d;
            denied_q <= denied_d;
            total_q  <= total_d;
        end
    end

    assign bus.enter         = enter_q;
    assign bus.exit          = exit_q;
    assign bus.count         = count_q;
    assign bus.full          = (count_q == cap_s[CW-1:0]);
    assign bus.empty         = (count_q == '0);
    assign bus.denied        = denied_q;
    assign bus.total_entries = total_q;
endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb/tb_parking_lot_ctrl.sv - directed self-checking bench for parking_lot_ctrl
module tb_parking_lot_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    parking_lot_ctrl_if #(.NUM_GATES(2), .CAPACITY(16)) bus ();

    parking_lot_ctrl #(.NUM_GATES(2), .CAPACITY(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;
    int exp_total = 0;
    int exp_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [1:0] i);
        bus.outer = o;
        bus.inner = i;
        tick();
    endtask

    // Apply one {outer,inner} code to gate g, other gate clear.
    task automatic seq(input int g, input logic [1:0] c);
        logic [1:0] o;
        logic [1:0] i;
        o    = '0;
        i    = '0;
        o[g] = c[1];
        i[g] = c[0];
        drive(o, i);
    endtask

    task automatic do_entry(input int g);
        seq(g, 2'b10);
        seq(g, 2'b11);
        seq(g, 2'b01);
        seq(g, 2'b00);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        bus.outer = '0;
        bus.inner = '0;
        tick();
        tick();
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_denied", 32'(bus.denied), 0);
        check("rst_total", 32'(bus.total_entries), 0);
        check("rst_pulses", 32'({bus.enter, bus.exit}), 0);
        reset = 1'b0;

        // Single entry on gate 0, checking the two-clock latency
        seq(0, 2'b10);
        check("ent_early", 32'(bus.enter), 0);
        seq(0, 2'b11);
        seq(0, 2'b01);
        seq(0, 2'b00);
        check("ent_pulse", 32'(bus.enter), 2'b01);
        check("ent_cnt_lag", 32'(bus.count), 0);
        tick();
        check("ent_pulse_end", 32'(bus.enter), 0);
        check("ent_count", 32'(bus.count), 1);
        check("ent_empty", 32'(bus.empty), 0);
        check("ent_total", 32'(bus.total_entries), 1);

        // Gate 1 car backs out: no pulse
        seq(1, 2'b10);
        seq(1, 2'b11);
        seq(1, 2'b10);
        seq(1, 2'b00);
        check("back_pulse", 32'({bus.enter, bus.exit}), 0);
        tick();
        check("back_count", 32'(bus.count), 1);

        // Sequence broken by an illegal code
        seq(0, 2'b10);
        seq(0, 2'b01);
        seq(0, 2'b00);
        check("abort_pulse", 32'({bus.enter, bus.exit}), 0);
        tick();
        check("abort_count", 32'(bus.count), 1);

        do_entry(0);
        do_entry(1);
        check("cnt3", 32'(bus.count), 3);

        // Exit on gate 1
        seq(1, 2'b01);
        seq(1, 2'b11);
        seq(1, 2'b10);
        seq(1, 2'b00);
        check("exit_pulse", 32'(bus.exit), 2'b10);
        tick();
        check("exit_count", 32'(bus.count), 2);
        check("exit_total", 32'(bus.total_entries), 3);

        exp_count = 2;
        exp_total = 3;
        for (int k = 0; k < 13; k++) begin
            do_entry(k % 2);
            exp_count++;
            exp_total++;
        end
        check("fill_count", 32'(bus.count), 32'(exp_count));
        check("fill_total", 32'(bus.total_entries), 32'(exp_total));
        check("fill_notfull", 32'(bus.full), 0);

        // Two entries at count 15: one counted, denied pulses
        drive(2'b11, 2'b00);
        drive(2'b11, 2'b11);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b00);
        check("dual_pulse", 32'(bus.enter), 2'b11);
        tick();
        check("dual_count", 32'(bus.count), 16);
        check("dual_full", 32'(bus.full), 1);
        check("dual_denied", 32'(bus.denied), 1);
        check("dual_total", 32'(bus.total_entries), 17);
        tick();
        check("dual_denied_end", 32'(bus.denied), 0);

        // Full: entry on gate 0 and exit on gate 1 net out
        drive(2'b01, 2'b10);
        drive(2'b11, 2'b11);
        drive(2'b10, 2'b01);
        drive(2'b00, 2'b00);
        check("net_enter", 32'(bus.enter), 2'b01);
        check("net_exit", 32'(bus.exit), 2'b10);
        tick();
        check("net_count", 32'(bus.count), 16);
        check("net_denied", 32'(bus.denied), 0);
        check("net_total", 32'(bus.total_entries), 18);

        // Single entry while full is denied and not tallied
        seq(0, 2'b10);
        seq(0, 2'b11);
        seq(0, 2'b01);
        seq(0, 2'b00);
        tick();
        check("over_denied", 32'(bus.denied), 1);
        check("over_count", 32'(bus.count), 16);
        check("over_total", 32'(bus.total_entries), 18);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_count", 32'(bus.count), 0);
        check("rst2_total", 32'(bus.total_entries), 0);
        check("rst2_empty", 32'(bus.empty), 1);

        // Exit at empty is discarded
        seq(0, 2'b01);
        seq(0, 2'b11);
        seq(0, 2'b10);
        seq(0, 2'b00);
        check("under_pulse", 32'(bus.exit), 2'b01);
        tick();
        check("under_count", 32'(bus.count), 0);
        check("under_empty", 32'(bus.empty), 1);
        check("under_denied", 32'(bus.denied), 0);

        // Reset while gate 0 is in EN2 abandons the sequence
        seq(0, 2'b10);
        seq(0, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seq(0, 2'b01);
        seq(0, 2'b00);
        check("midrst_pulse", 32'(bus.enter), 0);
        tick();
        check("midrst_pulse2", 32'(bus.enter), 0);
        check("midrst_count", 32'(bus.count), 0);

        // Reset in the cycle a pulse is pending: not counted
        seq(0, 2'b10);
        seq(0, 2'b11);
        seq(0, 2'b01);
        seq(0, 2'b00);
        check("pend_pulse", 32'(bus.enter), 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pend_count", 32'(bus.count), 0);
        check("pend_total", 32'(bus.total_entries), 0);
        tick();
        check("pend_count2", 32'(bus.count), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/parking_lot_ctrl.md
PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

Interface
REQ-001 SHALL have parameter NUM_GATES, default 2, number of independent two-sensor gates (1..8).
REQ-002 SHALL have parameter CAPACITY, default 16, maximum occupancy (1..255).
REQ-003 SHALL have derived localparam CW = $clog2(CAPACITY+1), count width.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port outer  input  NUM_GATES  per-gate outer beam sensor, 1 = blocked.
REQ-007 SHALL have port inner  input  NUM_GATES  per-gate inner beam sensor, 1 = blocked.
REQ-008 SHALL have port enter  output  NUM_GATES  per-gate one-cycle pulse, completed entry.
REQ-009 SHALL have port exit  output  NUM_GATES  per-gate one-cycle pulse, completed exit.
REQ-010 SHALL have port count  output  CW  current occupancy.
REQ-011 SHALL have port full  output  1  count == CAPACITY.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port denied  output  1  one-cycle pulse, one or more entries not counted because of saturation.
REQ-014 SHALL have port total_entries  output  16  counted entries since reset, wraps modulo 2^16.

Function
REQ-015 SHALL instantiate one gate FSM per gate, fully independent, with states IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
REQ-016 Gate FSM SHALL sample {outer,inner} every cycle and transition as follows:
  - IDLE: 10 -> EN1; 01 -> EX1; 00/11 -> IDLE.
  - EN1: 11 -> EN2; 00 -> IDLE; 10 holds.
  - EN2: 01 -> EN3; 10 -> EN1; 11 holds.
  - EN3: 00 -> IDLE with enter pulse; 11 -> EN2; 01 holds.
  - EX1: 11 -> EX2; 00 -> IDLE; 01 holds.
  - EX2: 10 -> EX3; 01 -> EX1; 11 holds.
  - EX3: 00 -> IDLE with exit pulse; 11 -> EX2; 10 holds.
  - Unlisted codes (e.g. EN1 sees 01): -> IDLE, no pulse.
REQ-017 enter[g]/exit[g] SHALL be registered and high for exactly the one cycle after the edge on which the qualifying transition occurs.
REQ-018 Per cycle, E = popcount(enter) and X = popcount(exit); count SHALL update on the next edge to clamp(count + E - X, 0, CAPACITY).
REQ-019 Arithmetic SHALL be done at CW+4 bits, signed; no intermediate wrap.
REQ-020 Simultaneous enter and exit on different gates SHALL net out (E=1, X=1 leaves count unchanged, even when full or empty).
REQ-021 When count + E - X > CAPACITY, count SHALL become CAPACITY and denied SHALL pulse on that same update edge; total_entries SHALL add only the entries actually counted (CAPACITY - count + X).
REQ-022 When count + E - X < 0, count SHALL become 0; no error flag; exits past empty are discarded.
REQ-023 full, empty SHALL be combinational decodes of registered count.
REQ-024 total_entries SHALL wrap 0xFFFF -> 0x0000 silently.
REQ-025 Latency sensors-to-count SHALL be exactly 2 clocks: final 00 sample edge -> pulse; pulse -> count.

Reset
REQ-026 While reset is high at a clock edge, all FSMs SHALL go to IDLE and enter=0, exit=0, count=0, empty=1, full=0, denied=0, total_entries=0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence; no pulse SHALL be generated for it after reset releases.
REQ-028 Pulses pending in the cycle reset asserts SHALL NOT be counted.

Verification
REQ-029 Gate 0 sequence 10,11,01,00 (one cycle each) after reset -> enter[0] high 1 cycle, count 0->1 two cycles after 00, empty 1->0, total_entries=1.
REQ-030 Gate 1 sequence 10,11,10,00 (car backs out) -> no pulse, count unchanged; then 01,11,10,00 at count 3 -> exit[1], count 2.
REQ-031 Count=15, gates 0 and 1 complete entries in the same cycle -> count 16, full=1, denied pulses 1 cycle, total_entries +1.
REQ-032 Count=16, gate 0 entry and gate 1 exit in same cycle -> count stays 16, denied=0, total_entries +1.
REQ-033 Count=0, exit completes on gate 0 -> count stays 0, empty=1, no denied.
REQ-034 Reset pulsed while gate 0 in EN2, then inputs 01,00 -> no enter pulse, count=0.
